// File: rtl/apb_master_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_pkg
//   Shared definitions for the APB requester bridge:
//     - APB address / data widths
//     - FSM state encoding (IDLE, SETUP, ACCESS)
//   Imported by apb_master_bridge and apb_wait_timer.
// ---------------------------------------------------------------------------
package apb_master_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Width of a counter able to hold values 0..limit inclusive.
  function automatic int wait_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ---------------------------------------------------------------------------
// apb_wait_timer
//   Saturating counter of ACCESS-phase wait cycles. Only instantiated when
//   the bridge is built with APB_MASTER_TIMEOUT_EN defined.
//
//   Ports
//     clk_i       clock (rising edge)
//     rst_ni      asynchronous active-low reset, clears the count
//     clear_i     synchronous clear (asserted when a command is accepted)
//     count_en_i  count one wait cycle (ACCESS with PREADY = 0)
//     expired_o   count has reached LIMIT
// ---------------------------------------------------------------------------
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CNT_W = wait_cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturate at LIMIT so the expired flag stays asserted until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//   Converts a valid/ready command stream into single APB transfers and
//   returns a valid/ready response. One transfer outstanding at a time.
//
//   Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
//   that waits TIMEOUT_CYCLES cycles with PREADY low. Without the macro the
//   bridge waits indefinitely and rsp_timeout is tied low.
//
//   Ports
//     PCLK, PRESETn             clock, asynchronous active-low reset
//     cmd_valid/cmd_ready       command handshake
//     cmd_write/addr/wdata      command payload
//     rsp_valid/rsp_ready       response handshake
//     rsp_rdata/err/timeout     response payload
//     PSEL/PENABLE/PWRITE/
//     PADDR/PWDATA              APB requester outputs (all registered)
//     PRDATA/PREADY/PSLVERR     APB completer inputs
// ---------------------------------------------------------------------------
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e            state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic [APB_DATA_W-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [APB_DATA_W-1:0] rsp_rdata_q;

  logic cmd_accept;
  logic wait_expired;

  // Accepting only when no response is pending keeps exactly one transfer
  // in flight and makes cmd_ready rise the cycle after the response is taken.
  assign cmd_ready  = (state_q == IDLE) && !rsp_valid_q;
  assign cmd_accept = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic rsp_timeout_q;

  // Cleared on acceptance (entry to SETUP); counts ACCESS cycles with PREADY low.
  apb_wait_timer #(
    .LIMIT      (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i      (PCLK),
    .rst_ni     (PRESETn),
    .clear_i    (cmd_accept),
    .count_en_i ((state_q == ACCESS) && !PREADY),
    .expired_o  (wait_expired)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  // The limit only matters when the timeout logic is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wait_expired       = 1'b0;
  assign rsp_timeout        = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      // Anything in flight is dropped; no response survives reset.
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rsp_valid_q) begin
            // Response payload is held untouched until consumed.
            if (rsp_ready) begin
              rsp_valid_q <= 1'b0;
            end
          end else if (cmd_valid) begin
            // cmd_ready is implied here (IDLE, no pending response).
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            pwdata_q  <= cmd_wdata;
          end
        end

        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end

        ACCESS: begin
          // Completion takes priority over a simultaneous timeout.
          if (PREADY) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= PSLVERR;
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
          end else if (wait_expired) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_rdata_q   <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b1;
`endif
          end
        end

        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge. Inputs change 1 time unit after the
//   rising edge and outputs are sampled at the same point. Timeout steps are
//   compiled in when APB_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_bridge #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Present a command for one edge; cmd_ready must be 1 when called.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel",      32'(PSEL),        32'd0);
    chk("rst_penable",   32'(PENABLE),     32'd0);
    chk("rst_pwrite",    32'(PWRITE),      32'd0);
    chk("rst_paddr",     PADDR,            32'h0);
    chk("rst_pwdata",    PWDATA,           32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid),   32'd0);
    chk("rst_rsp_err",   32'(rsp_err),     32'd0);
    chk("rst_rsp_to",    32'(rsp_timeout), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata,        32'h0);
    PRESETn = 1'b1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---- zero-wait write ----
    PREADY  = 1'b1;
    PRDATA  = 32'hFFFF_FFFF;
    PSLVERR = 1'b0;
    issue(1'b1, 32'h4000_0010, 32'h1234_5678);
    chk("wr_setup_psel",    32'(PSEL),      32'd1);
    chk("wr_setup_penable", 32'(PENABLE),   32'd0);
    chk("wr_setup_paddr",   PADDR,          32'h4000_0010);
    chk("wr_setup_pwdata",  PWDATA,         32'h1234_5678);
    chk("wr_setup_pwrite",  32'(PWRITE),    32'd1);
    chk("wr_setup_cmd_rdy", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_acc_psel",      32'(PSEL),      32'd1);
    chk("wr_acc_penable",   32'(PENABLE),   32'd1);
    chk("wr_acc_paddr",     PADDR,          32'h4000_0010);
    tick();
    chk("wr_rsp_valid",     32'(rsp_valid),   32'd1);
    chk("wr_rsp_err",       32'(rsp_err),     32'd0);
    chk("wr_rsp_timeout",   32'(rsp_timeout), 32'd0);
    chk("wr_rsp_rdata",     rsp_rdata,        32'h0);
    chk("wr_done_psel",     32'(PSEL),        32'd0);
    chk("wr_done_penable",  32'(PENABLE),     32'd0);
    chk("wr_done_paddr",    PADDR,            32'h4000_0010);
    chk("wr_done_cmd_rdy",  32'(cmd_ready),   32'd0);
    consume();
    chk("wr_after_valid",   32'(rsp_valid), 32'd0);
    chk("wr_after_cmd_rdy", 32'(cmd_ready), 32'd1);

    // ---- read with 3 wait states; garbage on PRDATA/PSLVERR while waiting ----
    PREADY  = 1'b0;
    PRDATA  = 32'h1111_1111;
    PSLVERR = 1'b1;
    issue(1'b0, 32'h4000_0020, 32'h0);
    chk("rd_setup_psel",    32'(PSEL),    32'd1);
    chk("rd_setup_penable", 32'(PENABLE), 32'd0);
    chk("rd_setup_pwrite",  32'(PWRITE),  32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rd_acc%0d_psel", i),    32'(PSEL),      32'd1);
      chk($sformatf("rd_acc%0d_penable", i), 32'(PENABLE),   32'd1);
      chk($sformatf("rd_acc%0d_paddr", i),   PADDR,          32'h4000_0020);
      chk($sformatf("rd_acc%0d_rsp_v", i),   32'(rsp_valid), 32'd0);
      if (i == 3) begin
        PREADY  = 1'b1;
        PRDATA  = 32'hCAFE_F00D;
        PSLVERR = 1'b0;
      end
    end
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata,      32'hCAFE_F00D);
    chk("rd_rsp_err",   32'(rsp_err),   32'd0);
    chk("rd_done_psel", 32'(PSEL),      32'd0);
    consume();

    // ---- error response ----
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = 32'hDEAD_DEAD;
    issue(1'b0, 32'h4000_0030, 32'h0);
    tick();
    tick();
    chk("err_rsp_valid",   32'(rsp_valid),   32'd1);
    chk("err_rsp_err",     32'(rsp_err),     32'd1);
    chk("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("err_rsp_rdata",   rsp_rdata,        32'hDEAD_DEAD);

    // ---- backpressure: response held, next command waiting ----
    PSLVERR   = 1'b0;
    PRDATA    = 32'h2222_2222;
    cmd_write = 1'b1;
    cmd_addr  = 32'h4000_0040;
    cmd_wdata = 32'hA5A5_A5A5;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d_cmd_ready", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rsp_rdata", i), rsp_rdata,      32'hDEAD_DEAD);
      chk($sformatf("bp%0d_rsp_err", i),   32'(rsp_err),   32'd1);
      chk($sformatf("bp%0d_psel", i),      32'(PSEL),      32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("bp_hs_psel",      32'(PSEL),      32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_psel",   32'(PSEL),   32'd1);
    chk("bp_next_paddr",  PADDR,       32'h4000_0040);
    chk("bp_next_pwdata", PWDATA,      32'hA5A5_A5A5);
    chk("bp_next_pwrite", 32'(PWRITE), 32'd1);
    tick();
    tick();
    chk("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_rsp_err",   32'(rsp_err),   32'd0);
    chk("bp_next_rsp_rdata", rsp_rdata,      32'h0);
    consume();

`ifdef APB_MASTER_TIMEOUT_EN
    // ---- timeout abort with PREADY stuck low ----
    PREADY = 1'b0;
    PRDATA = 32'h3333_3333;
    issue(1'b0, 32'h4000_0050, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("to%0d_psel", i),    32'(PSEL),      32'd1);
      chk($sformatf("to%0d_penable", i), 32'(PENABLE),   32'd1);
      chk($sformatf("to%0d_rsp_v", i),   32'(rsp_valid), 32'd0);
    end
    tick();
    chk("to_psel",        32'(PSEL),        32'd0);
    chk("to_penable",     32'(PENABLE),     32'd0);
    chk("to_rsp_valid",   32'(rsp_valid),   32'd1);
    chk("to_rsp_err",     32'(rsp_err),     32'd1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_rsp_rdata",   rsp_rdata,        32'h0);
    consume();

    // ---- PREADY on the limit cycle: completion wins ----
    PRDATA = 32'h600D_600D;
    issue(1'b0, 32'h4000_0054, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("lim%0d_psel", i), 32'(PSEL), 32'd1);
      if (i == 4) PREADY = 1'b1;
    end
    tick();
    chk("lim_rsp_valid",   32'(rsp_valid),   32'd1);
    chk("lim_rsp_err",     32'(rsp_err),     32'd0);
    chk("lim_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("lim_rsp_rdata",   rsp_rdata,        32'h600D_600D);
    consume();
`else
    // ---- no timeout: ACCESS waits indefinitely ----
    PREADY = 1'b0;
    PRDATA = 32'h3333_3333;
    issue(1'b0, 32'h4000_0050, 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("wait%0d_penable", i), 32'(PENABLE),     32'd1);
      chk($sformatf("wait%0d_rsp_v", i),   32'(rsp_valid),   32'd0);
      chk($sformatf("wait%0d_rsp_to", i),  32'(rsp_timeout), 32'd0);
    end
    PREADY = 1'b1;
    PRDATA = 32'h600D_600D;
    tick();
    chk("wait_rsp_valid",   32'(rsp_valid),   32'd1);
    chk("wait_rsp_err",     32'(rsp_err),     32'd0);
    chk("wait_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("wait_rsp_rdata",   rsp_rdata,        32'h600D_600D);
    consume();
`endif

    // ---- reset in the middle of ACCESS ----
    PREADY = 1'b0;
    PRDATA = 32'h4444_4444;
    issue(1'b1, 32'h4000_0060, 32'h7777_7777);
    tick();
    tick();
    chk("mid_pre_penable", 32'(PENABLE), 32'd1);
    #3;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel",      32'(PSEL),      32'd0);
    chk("mid_rst_penable",   32'(PENABLE),   32'd0);
    chk("mid_rst_pwrite",    32'(PWRITE),    32'd0);
    chk("mid_rst_paddr",     PADDR,          32'h0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    PREADY = 1'b1;
    tick();
    PRESETn = 1'b1;
    tick();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_psel",      32'(PSEL),      32'd0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    PSLVERR = 1'b0;
    issue(1'b1, 32'h4000_0070, 32'h0BAD_BEEF);
    chk("fresh_psel",  32'(PSEL), 32'd1);
    chk("fresh_paddr", PADDR,     32'h4000_0070);
    tick();
    tick();
    chk("fresh_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("fresh_rsp_err",   32'(rsp_err),   32'd0);
    chk("fresh_rsp_rdata", rsp_rdata,      32'h0);
    consume();
    chk("fresh_after_valid", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
